gearbox_tx_seq_ctrl: RTL and testbench

- Sequences the 32-bit TX gearbox that follows the 64b/66b encoder.
- Each 66-bit block {hdr[1:0], data[63:0]} enters the gearbox as two 32-bit words over two cycles. The gearbox drains 32 bits per cycle, so 32 blocks (64 input cycles) produce 66 output words.
- The block paces this with a 66-cycle frame. It gives the gearbox a block/half index and gives the encoder a ready/pause.

---
 rtl/gearbox_tx_seq_ctrl_pkg.sv | 51 +++++
 rtl/gearbox_tx_seq_ctrl_if.sv | 26 ++
 rtl/gearbox_tx_seq_ctrl_frame_counter.sv | 57 +++++
 rtl/gearbox_tx_seq_ctrl.sv | 111 +++++++++++
 tb/tb_gearbox_tx_seq_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/gearbox_tx_seq_ctrl_pkg.sv
// Shared constants, state type and output decode for the 64b/66b TX gearbox sequencer.
package gearbox_pkg;

    localparam int DATA_WIDTH       = 32;
    localparam int HDR_WIDTH        = 2;
    localparam int BLOCKS_PER_FRAME = 32;
    localparam int PAUSE_CYCLES     = BLOCKS_PER_FRAME * HDR_WIDTH / DATA_WIDTH;
    localparam int RUN_CYCLES       = 2 * BLOCKS_PER_FRAME;
    localparam int FRAME_CYCLES     = RUN_CYCLES + PAUSE_CYCLES;
    localparam int CNT_W            = 7;
    localparam int SEQ_W            = 6;

    localparam logic [SEQ_W-1:0] SEQ_PAUSE_VAL = 6'd32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } gbx_seq_state_t;

    typedef struct packed {
        logic             enc_ready;
        logic [SEQ_W-1:0] seq;
        logic             half;
        logic             hdr_valid;
        logic             pause;
        logic             frame_start;
    } gbx_out_t;

    // Output image for a given state and frame cycle; IDLE maps to all zeros.
    function automatic gbx_out_t gbx_decode(gbx_seq_state_t st, logic [CNT_W-1:0] cnt);
        gbx_out_t o;
        o = '0;
        case (st)
            RUN: begin
                o.enc_ready   = 1'b1;
                o.seq         = cnt[CNT_W-1:1];
                o.half        = cnt[0];
                o.hdr_valid   = ~cnt[0];
                o.frame_start = (cnt == '0);
            end
            PAUSE: begin
                o.seq   = SEQ_PAUSE_VAL;
                o.pause = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/gearbox_tx_seq_ctrl_if.sv
// Encoder/gearbox side signals of the TX gearbox sequencer.
interface gearbox_tx_seq_ctrl_if;

    logic       i_enable;
    logic       i_enc_valid;
    logic       o_enc_ready;
    logic [5:0] o_gbx_seq;
    logic       o_gbx_half;
    logic       o_gbx_hdr_valid;
    logic       o_gbx_pause;
    logic       o_frame_start;
    logic       o_seq_err;

    modport master (
        output i_enable, i_enc_valid,
        input  o_enc_ready, o_gbx_seq, o_gbx_half, o_gbx_hdr_valid,
        input  o_gbx_pause, o_frame_start, o_seq_err
    );

    modport slave (
        input  i_enable, i_enc_valid,
        output o_enc_ready, o_gbx_seq, o_gbx_half, o_gbx_hdr_valid,
        output o_gbx_pause, o_frame_start, o_seq_err
    );

endinterface

// File: rtl/gearbox_tx_seq_ctrl_frame_counter.sv
// gbx_frame_counter: modulo-66 frame cycle counter that only stops on a block boundary.
module gbx_frame_counter
    import gearbox_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic             i_stop_req,
    output logic [CNT_W-1:0] o_cnt_nxt,
    output logic             o_wrap,
    output logic             o_run_done,
    output logic             o_stop
);

    localparam logic [CNT_W-1:0] LAST_RUN   = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(FRAME_CYCLES - 1);

    logic             r_active;
    logic [CNT_W-1:0] r_cnt;
    logic             w_active_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_boundary;

    // Odd counts end a block or the pause; the last block must still be followed by its pause.
    assign w_boundary = r_active && r_cnt[0] && (r_cnt != LAST_RUN);
    assign o_stop     = w_boundary && i_stop_req;
    assign o_wrap     = r_active && (r_cnt == LAST_FRAME);
    assign o_run_done = r_active && (r_cnt == LAST_RUN);
    assign o_cnt_nxt  = w_cnt_nxt;

    always_comb begin
        w_active_nxt = r_active;
        w_cnt_nxt    = r_cnt;
        if (!r_active) begin
            w_active_nxt = i_start;
            w_cnt_nxt    = '0;
        end else if (o_stop) begin
            w_active_nxt = 1'b0;
            w_cnt_nxt    = '0;
        end else if (o_wrap) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_active <= w_active_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/gearbox_tx_seq_ctrl.sv
// TX gearbox sequencer: paces the encoder and indexes gearbox blocks over a 66-cycle frame.
// Optional protocol checker on o_seq_err is built when GBX_SEQ_CHECK_EN is defined.
module gearbox_tx_seq_ctrl
    import gearbox_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    gearbox_tx_seq_ctrl_if.slave  bus
);

    // state | meaning
    // IDLE  | stopped, outputs zero, counter at 0
    // RUN   | cnt 0..63, one encoder word per cycle
    // PAUSE | cnt 64..65, gearbox drains buffered header bits

    gbx_seq_state_t   r_state;
    gbx_out_t         r_out;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_wrap;
    logic             w_run_done;
    logic             w_stop;

    gbx_frame_counter u_frame_counter (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_start    (bus.i_enable),
        .i_stop_req (~bus.i_enable),
        .o_cnt_nxt  (w_cnt_nxt),
        .o_wrap     (w_wrap),
        .o_run_done (w_run_done),
        .o_stop     (w_stop)
    );

    // Outputs are decoded from the next count so they line up with the registered state.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_out   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.i_enable) begin
                        r_state <= RUN;
                        r_out   <= gbx_decode(RUN, w_cnt_nxt);
                    end else begin
                        r_out <= '0;
                    end
                end
                RUN: begin
                    if (w_stop) begin
                        r_state <= IDLE;
                        r_out   <= '0;
                    end else if (w_run_done) begin
                        r_state <= PAUSE;
                        r_out   <= gbx_decode(PAUSE, w_cnt_nxt);
                    end else begin
                        r_out <= gbx_decode(RUN, w_cnt_nxt);
                    end
                end
                PAUSE: begin
                    if (w_stop) begin
                        r_state <= IDLE;
                        r_out   <= '0;
                    end else if (w_wrap) begin
                        r_state <= RUN;
                        r_out   <= gbx_decode(RUN, w_cnt_nxt);
                    end else begin
                        r_out <= gbx_decode(PAUSE, w_cnt_nxt);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_out   <= '0;
                end
            endcase
        end
    end

    assign bus.o_enc_ready     = r_out.enc_ready;
    assign bus.o_gbx_seq       = r_out.seq;
    assign bus.o_gbx_half      = r_out.half;
    assign bus.o_gbx_hdr_valid = r_out.hdr_valid;
    assign bus.o_gbx_pause     = r_out.pause;
    assign bus.o_frame_start   = r_out.frame_start;

`ifdef GBX_SEQ_CHECK_EN
    logic r_seq_err;
    logic r_h0_valid;

    // r_h0_valid remembers that the first word of the current block was sent.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_seq_err  <= 1'b0;
            r_h0_valid <= 1'b0;
        end else begin
            r_h0_valid <= (r_state == RUN) && !r_out.half && bus.i_enc_valid;
            if (((r_state != RUN) && bus.i_enc_valid) ||
                ((r_state == RUN) && r_out.half && !bus.i_enc_valid && r_h0_valid)) begin
                r_seq_err <= 1'b1;
            end
        end
    end

    assign bus.o_seq_err = r_seq_err;
`else
    logic w_unused_valid;
    assign w_unused_valid = bus.i_enc_valid;
    assign bus.o_seq_err  = 1'b0;
`endif

endmodule

// File: tb/tb_gearbox_tx_seq_ctrl.sv
// Scoreboard bench for gearbox_tx_seq_ctrl: frame-position reference model plus a bit-level gearbox model.
module tb_gearbox_tx_seq_ctrl;

    typedef struct packed {
        logic       ready;
        logic [5:0] seq;
        logic       half;
        logic       hdrv;
        logic       pause;
        logic       fs;
        logic       err;
    } obs_t;

    typedef struct {
        obs_t o;
        bit   chk;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gearbox_tx_seq_ctrl_if bus ();

    gearbox_tx_seq_ctrl dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    int   n_vec = 0;
    int   n_err = 0;
    exp_t eq[$];

    // Reference model: running flag, position within the 66-cycle frame, sticky error.
    bit m_run = 0;
    int m_pos = 0;
    bit m_err = 0;
    bit m_h0v = 0;

    function automatic bit cur_ready();
        return m_run && (m_pos < 64);
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.ready = m_run && (m_pos < 64);
        o.seq   = !m_run ? 6'd0 : ((m_pos < 64) ? 6'(m_pos / 2) : 6'd32);
        o.half  = m_run && (m_pos < 64) && (m_pos % 2 == 1);
        o.hdrv  = m_run && (m_pos < 64) && (m_pos % 2 == 0);
        o.pause = m_run && (m_pos >= 64);
        o.fs    = m_run && (m_pos == 0);
        o.err   = m_err;
        return o;
    endfunction

    task automatic step(input bit en, input bit v, input bit rn, input bit chk);
        exp_t e;
        @(negedge clk);
        bus.i_enable    = en;
        bus.i_enc_valid = v;
        rst_n           = rn;
        if (!rn) begin
            m_run = 0; m_pos = 0; m_err = 0; m_h0v = 0;
        end else begin
`ifdef GBX_SEQ_CHECK_EN
            if (v && !(m_run && m_pos < 64)) m_err = 1;
            if (m_run && m_pos < 64 && (m_pos % 2 == 1) && !v && m_h0v) m_err = 1;
            m_h0v = m_run && m_pos < 64 && (m_pos % 2 == 0) && v;
`endif
            if (!m_run) begin
                if (en) begin m_run = 1; m_pos = 0; end
            end else if (!en && (m_pos % 2 == 1) && (m_pos != 63)) begin
                // end of a block (not the last) or end of the pause
                m_run = 0; m_pos = 0;
            end else begin
                m_pos = (m_pos + 1) % 66;
            end
        end
        e.o   = model_obs();
        e.chk = chk;
        eq.push_back(e);
    endtask

    task automatic run_to(input int pos);
        int g = 0;
        while (!(m_run && m_pos == pos) && g < 300) begin
            step(1, cur_ready(), 1, 0);
            g++;
        end
        n_vec++;
        if (g >= 300) begin
            n_err++;
            $display("FAIL run_to timeout: reached pos %0d, wanted %0d", m_pos, pos);
        end
    endtask

    // Gearbox bit model driven by the DUT's own sequencing outputs.
    logic [65:0]   blk [32];
    logic [2111:0] ref_bits;
    bit            bq[$];
    bit            gb_on = 0;
    int            gb_k  = 0;

    always begin
        exp_t        e;
        obs_t        a;
        logic [31:0] w;
        logic [31:0] rw;
        int          s;
        @(posedge clk);
        #1;
        if (eq.size() > 0) begin
            e = eq.pop_front();
            a = {bus.o_enc_ready, bus.o_gbx_seq, bus.o_gbx_half, bus.o_gbx_hdr_valid,
                 bus.o_gbx_pause, bus.o_frame_start, bus.o_seq_err};
            n_vec++;
            if (a !== e.o) begin
                n_err++;
                $display("FAIL outputs at %0t: got %h want %h", $time, a, e.o);
            end
            if (!e.chk) begin
                gb_on = 0;
            end else begin
                if (a.fs) begin
                    for (int b = 0; b < 32; b++) begin
                        blk[b] = {$urandom(), $urandom(), 2'($urandom_range(1, 2))};
                        ref_bits[66*b +: 66] = blk[b];
                    end
                    bq.delete();
                    gb_on = 1;
                    gb_k  = 0;
                end
                if (gb_on) begin
                    s = int'(a.seq);
                    if (s < 32) begin
                        if (a.hdrv)
                            for (int i = 0; i < 34; i++) bq.push_back(blk[s][i]);
                        else if (a.half && a.ready)
                            for (int i = 34; i < 66; i++) bq.push_back(blk[s][i]);
                    end
                    if ((a.ready || a.pause) && gb_k < 66) begin
                        n_vec++;
                        if (bq.size() < 32) begin
                            n_err++;
                            $display("FAIL gbx underflow word %0d: have %0d bits, need 32", gb_k, bq.size());
                        end else begin
                            for (int i = 0; i < 32; i++) w[i] = bq.pop_front();
                            rw = ref_bits[32*gb_k +: 32];
                            if (w !== rw) begin
                                n_err++;
                                $display("FAIL gbx word %0d: got %h want %h", gb_k, w, rw);
                            end
                        end
                        gb_k++;
                    end
                end
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        bus.i_enable    = 1'b0;
        bus.i_enc_valid = 1'b0;
        repeat (3) step(0, 0, 0, 0);

        // Continuous run with legal encoder traffic; gearbox stream checked bit-exact.
        repeat (200) step(1, cur_ready(), 1, 1);

        // Disable on a first-half word: finishes the block, then idles.
        run_to(10);
        repeat (4) step(0, 0, 1, 0);
        step(1, 0, 1, 0);

        // Disable at pause start: pause completes first.
        run_to(64);
        repeat (4) step(0, 0, 1, 0);

        // Mid-frame reset.
        run_to(40);
        step(1, 1, 0, 0);
        repeat (5) step(1, cur_ready(), 1, 0);

        // Encoder pushes during pause.
        run_to(64);
        step(1, 1, 1, 0);
        repeat (10) step(1, 0, 1, 0);

        // Randomized enable / valid / occasional reset.
        repeat (700) begin
            step(($urandom_range(0, 24) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 199) != 0), 0);
        end
        repeat (5) step(1, cur_ready(), 1, 0);

        repeat (3) @(posedge clk);
        #2;
        n_vec++;
        if (eq.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard drain: %0d left, want 0", eq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
